// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response/memory-port bundle shared by the arbiter and its neighbours
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_wdata_valid;
    logic              dc_wdata_ready;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              busy;
    logic              grant_owner;

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        output busy, grant_owner
    );

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata,
        input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata,
        output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        input  busy, grant_owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - alternating I/D-side arbiter for the single main-memory port
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // On a tie the side that did not own the previous transaction wins.
    logic win_dc;
    assign win_dc = bus.dc_req_valid && (!bus.ic_req_valid || !last_owner_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
        end
    end

    // Handshake outputs are held low while reset is asserted so no side sees a
    // grant or a beat in a cycle whose state is about to be discarded.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;

        bus.ic_req_ready    = 1'b0;
        bus.dc_req_ready    = 1'b0;
        bus.ic_resp_valid   = 1'b0;
        bus.dc_resp_valid   = 1'b0;
        bus.dc_wdata_ready  = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_wdata_valid = 1'b0;
        bus.ic_resp_data    = bus.mem_resp_data;
        bus.dc_resp_data    = bus.mem_resp_data;
        bus.mem_wdata       = bus.dc_wdata;
        bus.mem_req_addr    = addr_q;
        bus.mem_req_rw      = rw_q;
        bus.busy            = (state_q != S_IDLE);
        bus.grant_owner     = owner_q;

        case (state_q)
            S_IDLE: begin
                bus.ic_req_ready = !reset && bus.ic_req_valid && !win_dc;
                bus.dc_req_ready = !reset && win_dc;
                if (bus.ic_req_valid || bus.dc_req_valid) begin
                    owner_d      = win_dc;
                    last_owner_d = win_dc;
                    addr_d       = win_dc ? bus.dc_req_addr : bus.ic_req_addr;
                    rw_d         = win_dc && bus.dc_req_rw;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.mem_req_valid = !reset;
                if (bus.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = rw_q ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                bus.mem_wdata_valid = !reset && bus.dc_wdata_valid;
                bus.dc_wdata_ready  = !reset && bus.mem_wdata_ready;
                if (bus.dc_wdata_valid && bus.mem_wdata_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RDATA: begin
                bus.ic_resp_valid = !reset && bus.mem_resp_valid && !owner_q;
                bus.dc_resp_valid = !reset && bus.mem_resp_valid && owner_q;
                if (bus.mem_resp_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;

    typedef logic [127:0] w_t;
    typedef struct packed {
        logic              side;
        logic [DATA_W-1:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rexp_t             rq[$];
    logic [DATA_W-1:0] wq[$];
    rexp_t             r_e;
    logic [DATA_W-1:0] w_e;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check_eq(input string tag, input w_t obs, input w_t exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard consumers: every delivered read beat and accepted write beat
    // must match the next expected item queued by the stimulus.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ic_resp_valid || bus.dc_resp_valid) begin
                check_eq("resp_one", w_t'(bus.ic_resp_valid & bus.dc_resp_valid), w_t'(0));
                check_eq("resp_pending", w_t'(rq.size() != 0), w_t'(1));
                if (rq.size() != 0) begin
                    r_e = rq.pop_front();
                    check_eq("resp_side", w_t'(bus.dc_resp_valid), w_t'(r_e.side));
                    check_eq("resp_data", w_t'(bus.dc_resp_valid ? bus.dc_resp_data : bus.ic_resp_data),
                             w_t'(r_e.data));
                end
            end
            if (bus.mem_wdata_valid && bus.mem_wdata_ready) begin
                check_eq("wr_pending", w_t'(wq.size() != 0), w_t'(1));
                if (wq.size() != 0) begin
                    w_e = wq.pop_front();
                    check_eq("wr_data", w_t'(bus.mem_wdata), w_t'(w_e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_outputs_reset(input string tag);
        check_eq({tag, "_busy"}, w_t'(bus.busy), w_t'(0));
        check_eq({tag, "_grant"}, w_t'(bus.grant_owner), w_t'(0));
        check_eq({tag, "_hs"}, w_t'({bus.mem_req_valid, bus.ic_req_ready, bus.dc_req_ready,
                                     bus.ic_resp_valid, bus.dc_resp_valid,
                                     bus.mem_wdata_valid, bus.dc_wdata_ready}), w_t'(0));
    endtask

    // One full transaction from IDLE; the grant is expected in the current cycle.
    task automatic txn(input bit side, input bit rw, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] base, input int stall, input bit spur,
                       input bit hold, input bit toggle);
        int n;
        int h;
        int k;
        int pushed;
        if (side) begin
            bus.dc_req_valid = 1'b1;
            bus.dc_req_addr  = addr;
            bus.dc_req_rw    = rw;
        end else begin
            bus.ic_req_valid = 1'b1;
            bus.ic_req_addr  = addr;
        end
        #1;
        n = 0;
        while (!(side ? bus.dc_req_ready : bus.ic_req_ready) && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check_eq("acc_wait", w_t'(n), w_t'(0));
        check_eq("acc_other", w_t'(side ? bus.ic_req_ready : bus.dc_req_ready), w_t'(0));
        @(posedge clk);
        #1;
        if (!hold) begin
            if (side) bus.dc_req_valid = 1'b0;
            else bus.ic_req_valid = 1'b0;
        end
        bus.mem_resp_valid = spur;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_valid", w_t'(bus.mem_req_valid), w_t'(1));
            check_eq("stall_addr", w_t'(bus.mem_req_addr), w_t'(addr));
            check_eq("stall_rdy", w_t'({bus.ic_req_ready, bus.dc_req_ready}), w_t'(0));
            @(posedge clk);
            #1;
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check_eq("req_valid", w_t'(bus.mem_req_valid), w_t'(1));
        check_eq("req_addr", w_t'(bus.mem_req_addr), w_t'(addr));
        check_eq("req_rw", w_t'(bus.mem_req_rw), w_t'(rw));
        check_eq("req_grant", w_t'(bus.grant_owner), w_t'(side));
        check_eq("req_busy", w_t'(bus.busy), w_t'(1));
        @(posedge clk);
        #1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        if (rw) begin
            h = 0;
            k = 0;
            pushed = 0;
            while (h < BEATS && k < 40) begin
                bus.dc_wdata_valid = 1'b1;
                if (pushed == h) begin
                    bus.dc_wdata = base + DATA_W'(h);
                    wq.push_back(base + DATA_W'(h));
                    pushed++;
                end
                bus.mem_wdata_ready = toggle ? (k % 2 == 0) : 1'b1;
                @(negedge clk);
                check_eq("wr_valid", w_t'(bus.mem_wdata_valid), w_t'(1));
                check_eq("wr_ready", w_t'(bus.dc_wdata_ready), w_t'(bus.mem_wdata_ready));
                if (bus.mem_wdata_ready) h++;
                @(posedge clk);
                #1 k++;
            end
            check_eq("wr_beats", w_t'(h), w_t'(BEATS));
            bus.dc_wdata_valid  = 1'b0;
            bus.mem_wdata_ready = 1'b0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = base + DATA_W'(i);
                rq.push_back('{side: side, data: base + DATA_W'(i)});
                @(negedge clk);
                check_eq("rd_busy", w_t'(bus.busy), w_t'(1));
                check_eq("rd_rdy", w_t'({bus.ic_req_ready, bus.dc_req_ready}), w_t'(0));
                @(posedge clk);
                #1;
            end
            bus.mem_resp_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("done_idle", w_t'(bus.busy), w_t'(0));
    endtask

    initial begin
        bus.ic_req_valid    = 1'b0;
        bus.ic_req_addr     = '0;
        bus.dc_req_valid    = 1'b0;
        bus.dc_req_rw       = 1'b0;
        bus.dc_req_addr     = '0;
        bus.dc_wdata_valid  = 1'b0;
        bus.dc_wdata        = '0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_wdata_ready = 1'b0;
        bus.mem_resp_valid  = 1'b0;
        bus.mem_resp_data   = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs_reset("rst");

        txn(1'b0, 1'b0, 28'h1234567, 128'hA, 0, 1'b0, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 28'h0ABCDEF, 128'hC0DE_0000_0000_0000_0000_0000_0000_0100, 0, 1'b0, 1'b0, 1'b1);

        // Both sides request continuously from reset: grants alternate D, I, D, I.
        @(posedge clk);
        #1 do_reset();
        bus.ic_req_addr  = 28'h0000100;
        bus.dc_req_addr  = 28'h0000200;
        bus.dc_req_rw    = 1'b0;
        bus.ic_req_valid = 1'b1;
        bus.dc_req_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) txn(1'b1, 1'b0, 28'h0000200, 128'h2000 + 128'(g * 16), 0, 1'b0, 1'b1, 1'b0);
            else txn(1'b0, 1'b0, 28'h0000100, 128'h1000 + 128'(g * 16), 0, 1'b0, 1'b1, 1'b0);
        end
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;

        // Address phase stalled five cycles with a stray response pulse in it.
        txn(1'b0, 1'b0, 28'h0F0F0F0, 128'h5500, 5, 1'b1, 1'b1, 1'b0);
        bus.ic_req_valid = 1'b0;

        // Reset lands on the second beat of a D-side read.
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b0;
        bus.dc_req_addr  = 28'h0BEEF00;
        #1;
        check_eq("mr_acc", w_t'(bus.dc_req_ready), w_t'(1));
        @(posedge clk);
        #1 bus.dc_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 128'h7001;
        rq.push_back('{side: 1'b1, data: 128'h7001});
        @(posedge clk);
        #1 bus.mem_resp_data = 128'h7002;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.mem_resp_data = 128'h7003;
        @(negedge clk);
        check_outputs_reset("mr");
        txn(1'b0, 1'b0, 28'h0C0FFEE, 128'h9900, 0, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        check_eq("rq_empty", w_t'(rq.size()), w_t'(0));
        check_eq("wq_empty", w_t'(wq.size()), w_t'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
